// File: rtl/i2c_eeprom_slave.sv
// I2C slave emulating a small byte-addressed serial EEPROM (24xx-style protocol).
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe_o.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | not addressed, ignore bus until START
// DEV_ADDR  | shifting in device address + R/W
// ACK_DEV   | holding ACK for device address
// WORD_ADDR | shifting in word address
// ACK_WORD  | holding ACK for word address
// WR_DATA   | shifting in a write data byte
// ACK_WR    | holding ACK for write data byte
// RD_DATA   | shifting out a read data byte
// RD_MACK   | waiting for master ACK/NACK after a read byte
module i2c_eeprom_slave #(
  parameter logic [6:0]  ADDRESS   = 7'b1010000,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe_o
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_DEV, WORD_ADDR, ACK_WORD, WR_DATA, ACK_WR, RD_DATA, RD_MACK
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          oe_q, oe_d;
  logic [1:0]    scl_sync_q, sda_sync_q;
  logic          scl_hist_q, sda_hist_q;
  logic [7:0]    mem_q [MEM_DEPTH];
  logic          mem_we;

  logic          scl_s, sda_s;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]    shift_in;
  logic [AW-1:0] ptr_inc;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_hist_q & sda_s;
  assign shift_in  = {shreg_q[6:0], sda_s};
  assign ptr_inc   = ptr_q + AW'(1);
  assign sda_oe_o  = oe_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    shreg_d = shreg_q;
    oe_d    = oe_q;
    mem_we  = 1'b0;
    if (start_det) begin
      state_d = DEV_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        DEV_ADDR, WORD_ADDR, WR_DATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shreg_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            // The data byte is committed on its 8th rising edge, before the ACK.
            if (state_q == WR_DATA && cnt_q == 4'd7) begin
              mem_we = 1'b1;
              ptr_d  = ptr_inc;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (state_q == DEV_ADDR) begin
              if (shreg_q[7:1] == ADDRESS) begin
                oe_d    = 1'b1;
                state_d = ACK_DEV;
              end else begin
                state_d = IDLE;
              end
            end else if (state_q == WORD_ADDR) begin
              ptr_d   = shreg_q[AW-1:0];
              oe_d    = 1'b1;
              state_d = ACK_WORD;
            end else begin
              oe_d    = 1'b1;
              state_d = ACK_WR;
            end
          end
        end
        ACK_DEV: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (shreg_q[0]) begin
              shreg_d = mem_q[ptr_q];
              oe_d    = ~mem_q[ptr_q][7];
              state_d = RD_DATA;
            end else begin
              oe_d    = 1'b0;
              state_d = WORD_ADDR;
            end
          end
        end
        ACK_WORD, ACK_WR: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shreg_d = {shreg_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = '0;
              state_d = RD_MACK;
            end else begin
              oe_d = ~shreg_q[7];
            end
          end
        end
        RD_MACK: begin
          // cnt_q==1 marks "master ACKed, next byte already loaded".
          if (scl_rise && cnt_q == 4'd0) begin
            ptr_d = ptr_inc;
            if (!sda_s) begin
              shreg_d = mem_q[ptr_inc];
              cnt_d   = 4'd1;
            end else begin
              state_d = IDLE;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            oe_d    = ~shreg_q[7];
            cnt_d   = '0;
            state_d = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      shreg_q    <= '0;
      oe_q       <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      shreg_q    <= shreg_d;
      oe_q       <= oe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= shift_in;
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: a bit-banged I2C master with an expected-value queue
// filled when stimulus is driven and drained against observed ACKs/read bytes.
module tb_i2c_eeprom_slave;

  localparam int Q = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic scl;
  logic sda_m;
  logic sda_line;
  logic sda_oe;
  int   total  = 0;
  int   passed = 0;
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  logic [7:0] model [256];

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  i2c_eeprom_slave #(.ADDRESS(7'b1010000), .MEM_DEPTH(256)) dut (
    .clk      (clk),
    .rst_ni   (rst_n),
    .scl_i    (scl),
    .sda_i    (sda_line),
    .sda_oe_o (sda_oe)
  );

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl = 1'b0; wclk(Q);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; wclk(Q);
    scl = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl = 1'b0; wclk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wclk(Q);
    scl = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(Q);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b; wclk(Q);
    scl = 1'b1; wclk(Q);
    s = sda_line; wclk(Q);
    scl = 1'b0; wclk(Q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int n);
    logic s;
    for (int i = 7; i > 7 - n; i--) bus_bit(b[i], s);
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic s;
    write_bits(b, 8);
    bus_bit(1'b1, s);
    obs_q.push_back({7'b0, ~s});
  endtask

  task automatic read_byte(input logic mack);
    logic s;
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    bus_bit(~mack, s);
    sda_m = 1'b1;
    obs_q.push_back(b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    wclk(3);
    total++;
    if (sda_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", sda_oe); else passed++;
    total++;
    if (dut.ptr_q !== 8'h00) $display("FAIL reset_ptr: got %h want 00", dut.ptr_q); else passed++;
    total++;
    if (int'(dut.state_q) !== 0) $display("FAIL reset_state: got %0d want 0", int'(dut.state_q)); else passed++;
    rst_n = 1'b1;
    wclk(4);
  endtask

  task automatic test_write();
    logic [7:0] e, o;
    bus_start();
    exp_q.push_back(8'd1); write_byte(8'hA0);
    exp_q.push_back(8'd1); write_byte(8'h10);
    exp_q.push_back(8'd1); write_byte(8'h5A); model[8'h10] = 8'h5A;
    bus_stop();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      total++;
      if (o !== e) $display("FAIL write_ack[%0d]: got %h want %h", i, o, e); else passed++;
    end
    total++;
    if (sda_oe !== 1'b0) $display("FAIL write_stop_oe: got %b want 0", sda_oe); else passed++;
    total++;
    if (dut.mem_q[8'h10] !== 8'h5A) $display("FAIL write_mem: got %h want 5a", dut.mem_q[8'h10]); else passed++;
  endtask

  task automatic test_random_read();
    logic [7:0] e, o;
    bus_start();
    exp_q.push_back(8'd1); write_byte(8'hA0);
    exp_q.push_back(8'd1); write_byte(8'h10);
    bus_rstart();
    exp_q.push_back(8'd1); write_byte(8'hA1);
    exp_q.push_back(model[8'h10]); read_byte(1'b0);
    total++;
    if (sda_oe !== 1'b0) $display("FAIL rread_nack_oe: got %b want 0", sda_oe); else passed++;
    bus_stop();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      total++;
      if (o !== e) $display("FAIL rread[%0d]: got %h want %h", i, o, e); else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e, o;
    logic [7:0] a;
    bus_start();
    exp_q.push_back(8'd1); write_byte(8'hA0);
    exp_q.push_back(8'd1); write_byte(8'hFF);
    a = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'd1);
      write_byte(8'h11 * 8'(i + 1));
      model[a] = 8'h11 * 8'(i + 1);
      a = a + 8'd1;
    end
    bus_stop();
    bus_start();
    exp_q.push_back(8'd1); write_byte(8'hA0);
    exp_q.push_back(8'd1); write_byte(8'hFF);
    bus_rstart();
    exp_q.push_back(8'd1); write_byte(8'hA1);
    exp_q.push_back(8'h11); read_byte(1'b1);
    exp_q.push_back(8'h22); read_byte(1'b1);
    exp_q.push_back(8'h33); read_byte(1'b0);
    bus_stop();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      total++;
      if (o !== e) $display("FAIL wrap[%0d]: got %h want %h", i, o, e); else passed++;
    end
    total++;
    if (dut.mem_q[8'h00] !== 8'h22) $display("FAIL wrap_mem00: got %h want 22", dut.mem_q[8'h00]); else passed++;
  endtask

  task automatic test_wrong_addr();
    logic [7:0] e, o;
    bus_start();
    exp_q.push_back(8'd0); write_byte(8'hA2);
    exp_q.push_back(8'd0); write_byte(8'h10);
    exp_q.push_back(8'd0); write_byte(8'h77);
    bus_stop();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      total++;
      if (o !== e) $display("FAIL wrong_addr_ack[%0d]: got %h want %h", i, o, e); else passed++;
    end
    total++;
    if (dut.mem_q[8'h10] !== model[8'h10]) $display("FAIL wrong_addr_mem: got %h want %h", dut.mem_q[8'h10], model[8'h10]); else passed++;
    total++;
    if (dut.ptr_q !== 8'h02) $display("FAIL wrong_addr_ptr: got %h want 02", dut.ptr_q); else passed++;
  endtask

  task automatic test_abort();
    logic [7:0] e, o;
    bus_start();
    exp_q.push_back(8'd1); write_byte(8'hA0);
    exp_q.push_back(8'd1); write_byte(8'h10);
    write_bits(8'h99, 4);
    bus_stop();
    total++;
    if (dut.ptr_q !== 8'h10) $display("FAIL abort_ptr: got %h want 10", dut.ptr_q); else passed++;
    bus_start();
    exp_q.push_back(8'd1); write_byte(8'hA1);
    exp_q.push_back(model[8'h10]); read_byte(1'b0);
    bus_stop();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      total++;
      if (o !== e) $display("FAIL abort[%0d]: got %h want %h", i, o, e); else passed++;
    end
    total++;
    if (dut.ptr_q !== 8'h11) $display("FAIL abort_ptr_after_read: got %h want 11", dut.ptr_q); else passed++;
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] e, o;
    bus_start();
    exp_q.push_back(8'd1); write_byte(8'hA0);
    exp_q.push_back(8'd1); write_byte(8'h20);
    exp_q.push_back(8'd1); write_byte(8'h00); model[8'h20] = 8'h00;
    bus_stop();
    bus_start();
    exp_q.push_back(8'd1); write_byte(8'hA0);
    exp_q.push_back(8'd1); write_byte(8'h20);
    bus_rstart();
    exp_q.push_back(8'd1); write_byte(8'hA1);
    total++;
    if (sda_oe !== 1'b1) $display("FAIL midread_hold: got %b want 1", sda_oe); else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (sda_oe !== 1'b0) $display("FAIL midread_rst_oe: got %b want 0", sda_oe); else passed++;
    total++;
    if (dut.ptr_q !== 8'h00) $display("FAIL midread_rst_ptr: got %h want 00", dut.ptr_q); else passed++;
    total++;
    if (int'(dut.state_q) !== 0) $display("FAIL midread_rst_state: got %0d want 0", int'(dut.state_q)); else passed++;
    wclk(2);
    rst_n = 1'b1;
    wclk(4);
    bus_stop();
    bus_start();
    exp_q.push_back(8'd1); write_byte(8'hA1);
    exp_q.push_back(model[8'h00]); read_byte(1'b0);
    bus_stop();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      total++;
      if (o !== e) $display("FAIL midread[%0d]: got %h want %h", i, o, e); else passed++;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_random_read();
    test_wrap();
    test_wrong_addr();
    test_abort();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
